// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op codes, FSM states and helpers
// for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Magnitude of the w-bit two's-complement value held in v;
  // callers truncate the result back to w bits.
  function automatic logic [63:0] abs_w(
    input logic [63:0] v,
    input int          w
  );
    abs_w = v[w-1] ? (~v + 64'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// muldiv_core: shift-add multiply / restoring divide
// datapath with its own iteration counter.
module muldiv_core #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               flush_i,
  input  logic               div_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] res_o,
  output logic               last_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q;
  logic               div_q;
  logic [WIDTH:0]     sum, shf, diff;

  // acc holds {hi, lo}: product halves or {rem, quotient}
  always_comb begin
    sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
         + {1'b0, (acc_q[0] ? opb_q : '0)};
    shf  = acc_q[2*WIDTH-1:WIDTH-1];
    diff = shf - {1'b0, opb_q};
    if (div_q) begin
      if (diff[WIDTH])
        acc_d = {shf[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      else
        acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_d = {sum, acc_q[WIDTH-1:1]};
    end
  end

  // The owner commits res_o on the edge where last_o is set.
  assign res_o  = acc_d;
  assign last_o = (cnt_q == CW'(1));

  // Load operands, then step once per cycle until the count drains
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      cnt_q <= '0;
      acc_q <= '0;
      opb_q <= '0;
      div_q <= 1'b0;
    end else if (load_i) begin
      cnt_q <= CW'(WIDTH);
      acc_q <= {{WIDTH{1'b0}}, a_i};
      opb_q <= b_i;
      div_q <= div_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: HI/LO state, control FSM, sign fix-up
// and hazard stall for the multi-cycle mul/div engine.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             rd_req_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             stall_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  state_t             state_q;
  logic [WIDTH-1:0]   hi_q, lo_q, a_raw_q;
  logic               done_q, div_q, sa_q, sb_q, bz_q;
  logic               md_op, sgn_op, load, last;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] res;
  logic [WIDTH-1:0]   hi_d, lo_d;

  assign md_op  = ~op_i[2];
  assign sgn_op = ~op_i[0];
  assign load   = (state_q == IDLE) & start_i
                & ~flush_i & md_op;

  // Signed ops iterate on magnitudes
  always_comb begin
    a_mag = a_i;
    b_mag = b_i;
    if (sgn_op) begin
      a_mag = WIDTH'(abs_w(64'(a_i), WIDTH));
      b_mag = WIDTH'(abs_w(64'(b_i), WIDTH));
    end
  end

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .flush_i (flush_i),
    .div_i   (op_i[1]),
    .a_i     (a_mag),
    .b_i     (b_mag),
    .res_o   (res),
    .last_o  (last)
  );

  // Sign fix-up of the final iteration; divide-by-zero
  // bypasses the datapath value.
  always_comb begin
    {hi_d, lo_d} = res;
    if (div_q) begin
      if (bz_q) begin
        hi_d = a_raw_q;
        lo_d = '1;
      end else begin
        lo_d = (sa_q ^ sb_q) ? -res[WIDTH-1:0]
                             : res[WIDTH-1:0];
        hi_d = sa_q ? -res[2*WIDTH-1:WIDTH]
                    : res[2*WIDTH-1:WIDTH];
      end
    end else if (sa_q ^ sb_q) begin
      {hi_d, lo_d} = -res;
    end
  end

  // Control FSM with HI/LO and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      a_raw_q <= '0;
      done_q  <= 1'b0;
      div_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i && !flush_i) begin
            unique case (op_i)
              OP_MTHI: hi_q <= a_i;
              OP_MTLO: lo_q <= a_i;
              OP_MULT, OP_MULTU,
              OP_DIV, OP_DIVU: begin
                state_q <= BUSY;
                div_q   <= op_i[1];
                sa_q    <= sgn_op & a_i[WIDTH-1];
                sb_q    <= sgn_op & b_i[WIDTH-1];
                bz_q    <= (b_i == '0);
                a_raw_q <= a_i;
              end
              default: ;
            endcase
          end
        end
        BUSY: begin
          if (flush_i) begin
            state_q <= IDLE;
          end else if (last) begin
            state_q <= IDLE;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o  = (state_q == BUSY);
  assign done_o  = done_q;
  assign stall_o = busy_o & (start_i | rd_req_i);
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors and corner-case
// sequences for muldiv_unit (WIDTH=32 and WIDTH=8).
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, rdreq, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done, stall;
  logic [31:0] hi, lo;

  logic        start8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8;
  logic        rd8, fl8;
  logic        busy8, done8, stall8;
  logic [7:0]  hi8, lo8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start_i(start), .op_i(op),
    .a_i(a), .b_i(b), .rd_req_i(rdreq), .flush_i(flush),
    .busy_o(busy), .done_o(done), .stall_o(stall),
    .hi_o(hi), .lo_o(lo)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start_i(start8), .op_i(op8),
    .a_i(a8), .b_i(b8), .rd_req_i(rd8), .flush_i(fl8),
    .busy_o(busy8), .done_o(done8), .stall_o(stall8),
    .hi_o(hi8), .lo_o(lo8)
  );

  typedef struct {
    string       nm;
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Starts and ends on a negedge
  task automatic run_vec(input vec_t v);
    int nb, nd, g;
    start = 1'b1; op = v.op; a = v.a; b = v.b;
    @(negedge clk);
    start = 1'b0;
    nb = 0; nd = 0; g = 0;
    while (busy && g < 200) begin
      nb++;
      if (done) nd++;
      @(negedge clk);
      g++;
    end
    chk({v.nm, " busy_cycles"}, 64'(nb), 64'd32);
    chk({v.nm, " done"}, 64'(done), 64'd1);
    chk({v.nm, " hi"}, 64'(hi), 64'(v.hi));
    chk({v.nm, " lo"}, 64'(lo), 64'(v.lo));
    @(negedge clk);
    chk({v.nm, " done_single"}, 64'(nd + int'(done)), 64'd0);
  endtask

  initial begin
    int nb, ns, nd, g;
    vecs[0]  = '{"mult_m3x7",   OP_MULT,  32'hFFFF_FFFD, 32'd7,
                 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1]  = '{"divu_100_7",  OP_DIVU,  32'd100, 32'd7,
                 32'd2, 32'd14};
    vecs[2]  = '{"div_m7_2",    OP_DIV,   32'hFFFF_FFF9, 32'd2,
                 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{"div_5_0",     OP_DIV,   32'd5, 32'd0,
                 32'd5, 32'hFFFF_FFFF};
    vecs[4]  = '{"div_ovf",     OP_DIV,   32'h8000_0000,
                 32'hFFFF_FFFF, 32'd0, 32'h8000_0000};
    vecs[5]  = '{"multu_2p32",  OP_MULTU, 32'h0001_0000,
                 32'h0001_0000, 32'd1, 32'd0};
    vecs[6]  = '{"multu_max",   OP_MULTU, 32'hFFFF_FFFF,
                 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1};
    vecs[7]  = '{"div_m7_0",    OP_DIV,   32'hFFFF_FFF9, 32'd0,
                 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[8]  = '{"div_7_m2",    OP_DIV,   32'd7, 32'hFFFF_FFFE,
                 32'd1, 32'hFFFF_FFFD};
    vecs[9]  = '{"mult_m1xm1",  OP_MULT,  32'hFFFF_FFFF,
                 32'hFFFF_FFFF, 32'd0, 32'd1};
    vecs[10] = '{"divu_max_2",  OP_DIVU,  32'hFFFF_FFFF, 32'd2,
                 32'd1, 32'h7FFF_FFFF};

    rst = 1'b1; start = 1'b0; rdreq = 1'b0; flush = 1'b0;
    op = 3'd0; a = '0; b = '0;
    start8 = 1'b0; op8 = 3'd0; a8 = '0; b8 = '0;
    rd8 = 1'b0; fl8 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // Stall while busy, re-presented op held off
    start = 1'b1; op = OP_MULTU;
    a = 32'h0001_0000; b = 32'h0001_0000; rdreq = 1'b1;
    @(negedge clk);
    nb = 0; ns = 0; g = 0;
    while (busy && g < 200) begin
      nb++;
      if (stall) ns++;
      @(negedge clk);
      g++;
    end
    chk("stall_busy_cycles", 64'(nb), 64'd32);
    chk("stall_cycles", 64'(ns), 64'd32);
    chk("stall_idle", 64'(stall), 64'd0);
    chk("mfhi_new_hi", 64'(hi), 64'd1);
    chk("mfhi_new_lo", 64'(lo), 64'd0);
    @(negedge clk);
    chk("reaccept_busy", 64'(busy), 64'd1);
    start = 1'b0; rdreq = 1'b0;
    g = 0;
    while (busy && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("reaccept_end", 64'(busy), 64'd0);
    @(negedge clk);

    // Flush at iteration 10
    start = 1'b1; op = OP_MULT;
    a = 32'hFFFF_FFFD; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_flush_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_hi", 64'(hi), 64'd1);
    chk("flush_lo", 64'(lo), 64'd0);
    nd = int'(done);
    repeat (40) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("flush_no_done", 64'(nd), 64'd0);
    chk("flush_hi_late", 64'(hi), 64'd1);

    // flush_i beats start_i
    start = 1'b1; flush = 1'b1; op = OP_MULT;
    @(negedge clk);
    chk("flush_pri_busy", 64'(busy), 64'd0);
    op = OP_MTHI; a = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("flush_pri_hi", 64'(hi), 64'd1);
    start = 1'b0; flush = 1'b0;

    // MTHI then MTLO
    start = 1'b1; op = OP_MTHI; a = 32'h1234_5678;
    @(negedge clk);
    chk("mthi_hi", 64'(hi), 64'h1234_5678);
    chk("mthi_busy", 64'(busy | done), 64'd0);
    op = OP_MTLO; a = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo_lo", 64'(lo), 64'h9ABC_DEF0);
    chk("mtlo_hi", 64'(hi), 64'h1234_5678);
    chk("mtlo_busy", 64'(busy | done), 64'd0);

    // Reset in cycle 15 of a DIV
    start = 1'b1; op = OP_DIV; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    rst = 1'b0;
    run_vec('{"divu_9_3", OP_DIVU, 32'd9, 32'd3,
              32'd0, 32'd3});

    // WIDTH=8 signed multiply of min*min
    start8 = 1'b1; op8 = OP_MULT; a8 = 8'h80; b8 = 8'h80;
    @(negedge clk);
    start8 = 1'b0;
    nb = 0; g = 0;
    while (busy8 && g < 50) begin
      nb++;
      @(negedge clk);
      g++;
    end
    chk("w8_busy_cycles", 64'(nb), 64'd8);
    chk("w8_done", 64'(done8), 64'd1);
    chk("w8_hi", 64'(hi8), 64'h40);
    chk("w8_lo", 64'(lo8), 64'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
